// File: rtl/dff_link_pkg.sv
// Shared types and line levels for the serial bit link.
package dff_link_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/dff_tx_bit_counter.sv
// Data-bit counter for the transmitter: clears on DATA entry, saturates at WIDTH-1.
module dff_tx_bit_counter #(
    parameter int WIDTH = 8,
    localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic last_o
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign last_o = (count_q == CW'(WIDTH - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !last_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dff_serial_tx.sv
// Framed parallel-in/serial-out transmitter: START, WIDTH data bits, optional parity, STOP.
// Define DFF_SERIAL_TX_PARITY_EN to insert an even-parity bit after the data bits.
module dff_serial_tx
    import dff_link_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             q,
    output logic             busy,
    output logic             done
);

    tx_state_t        state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;
    logic             next_bit;
    logic             q_q;
    logic             busy_q;
    logic             done_q;
    logic             ready_q;
    logic             bit_last;
`ifdef DFF_SERIAL_TX_PARITY_EN
    logic             parity_q;
`endif

    // The bit leaving the shift register now is the one q shows next cycle.
    assign next_bit = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];
    assign shreg_d  = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);

    dff_tx_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (state_q == START),
        .en_i   (state_q == DATA),
        .last_o (bit_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            q_q      <= LINE_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
`ifdef DFF_SERIAL_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (load_valid && ready_q) begin
                        shreg_q  <= data_in;
`ifdef DFF_SERIAL_TX_PARITY_EN
                        parity_q <= ^data_in;
`endif
                        state_q  <= START;
                        q_q      <= START_BIT;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                    end
                end
                START: begin
                    q_q     <= next_bit;
                    shreg_q <= shreg_d;
                    state_q <= DATA;
                end
                DATA: begin
                    if (bit_last) begin
`ifdef DFF_SERIAL_TX_PARITY_EN
                        state_q <= PARITY;
                        q_q     <= parity_q;
`else
                        state_q <= STOP;
                        q_q     <= STOP_BIT;
                        done_q  <= 1'b1;
`endif
                    end else begin
                        q_q     <= next_bit;
                        shreg_q <= shreg_d;
                    end
                end
`ifdef DFF_SERIAL_TX_PARITY_EN
                PARITY: begin
                    state_q <= STOP;
                    q_q     <= STOP_BIT;
                    done_q  <= 1'b1;
                end
`endif
                STOP: begin
                    state_q <= IDLE;
                    q_q     <= LINE_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    q_q     <= LINE_IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign q          = q_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign load_ready = ready_q;

endmodule

// File: tb/tb_dff_serial_tx.sv
// Directed bench for dff_serial_tx: one LSB-first and one MSB-first instance, WIDTH=8.
module tb_dff_serial_tx;

`ifdef DFF_SERIAL_TX_PARITY_EN
    localparam int FRAME_LEN = 11;
`else
    localparam int FRAME_LEN = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       lv_l = 1'b0, lv_m = 1'b0;
    logic       rdy_l, q_l, busy_l, done_l;
    logic       rdy_m, q_m, busy_m, done_m;
    int         tests  = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    dff_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(lv_l),
        .load_ready(rdy_l), .q(q_l), .busy(busy_l), .done(done_l)
    );

    dff_serial_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .load_valid(lv_m),
        .load_ready(rdy_m), .q(q_m), .busy(busy_m), .done(done_m)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, " q_l"},    32'(q_l),    32'd1);
        check({tag, " rdy_l"},  32'(rdy_l),  32'd1);
        check({tag, " busy_l"}, 32'(busy_l), 32'd0);
        check({tag, " done_l"}, 32'(done_l), 32'd0);
        check({tag, " q_m"},    32'(q_m),    32'd1);
        check({tag, " busy_m"}, 32'(busy_m), 32'd0);
    endtask

    // Called at the negedge where START should be on the line; order[7] is the first data bit sent.
    task automatic check_frame(input bit sel, input logic [7:0] order, input logic par, input string tag);
        logic exp_q;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i == 0)                  exp_q = 1'b0;
            else if (i <= 8)             exp_q = order[8-i];
            else if (i == FRAME_LEN - 1) exp_q = 1'b1;
            else                         exp_q = par;
            check($sformatf("%s q[%0d]", tag, i),    32'(sel ? q_m : q_l),       32'(exp_q));
            check($sformatf("%s busy[%0d]", tag, i), 32'(sel ? busy_m : busy_l), 32'd1);
            check($sformatf("%s done[%0d]", tag, i), 32'(sel ? done_m : done_l), 32'(i == FRAME_LEN - 1));
            check($sformatf("%s rdy[%0d]", tag, i),  32'(sel ? rdy_m : rdy_l),  32'd0);
            @(negedge clk);
        end
        check({tag, " end q"},    32'(sel ? q_m : q_l),       32'd1);
        check({tag, " end busy"}, 32'(sel ? busy_m : busy_l), 32'd0);
        check({tag, " end done"}, 32'(sel ? done_m : done_l), 32'd0);
        check({tag, " end rdy"},  32'(sel ? rdy_m : rdy_l),   32'd1);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic [7:0] order,
                        input logic par, input string tag);
        @(negedge clk);
        data_in = d;
        if (sel) lv_m = 1'b1; else lv_l = 1'b1;
        @(negedge clk);
        lv_l = 1'b0;
        lv_m = 1'b0;
        data_in = ~d;
        check_frame(sel, order, par, tag);
    endtask

    initial begin
        int first_acc;
        int second_acc;
        logic exp_q;

        // Reset held for 10 cycles, then released; the line must stay idle.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0 || i == 9) check_idle("reset");
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_idle("post_reset");
        end

        send(1'b0, 8'hA5, 8'b10100101, 1'b0, "lsb_A5");
        send(1'b1, 8'h81, 8'b10000001, 1'b0, "msb_81");

        // load_valid held high: second accept exactly one idle cycle after STOP.
        @(negedge clk);
        data_in = 8'h0F;
        lv_l = 1'b1;
        first_acc = 0;
        second_acc = -1;
        for (int c = 1; c <= 20 && second_acc < 0; c++) begin
            @(negedge clk);
            if (c == 3) data_in = 8'hF0;
            if (c <= FRAME_LEN) begin
                if (c == 1)              exp_q = 1'b0;
                else if (c <= 9)         exp_q = (c <= 5) ? 1'b1 : 1'b0;
                else if (c == FRAME_LEN) exp_q = 1'b1;
                else                     exp_q = 1'b0;
                check($sformatf("hold_0F q[%0d]", c - 1), 32'(q_l), 32'(exp_q));
            end
            if (rdy_l && lv_l) second_acc = c;
        end
        check("hold accept gap", 32'(second_acc - first_acc), 32'(FRAME_LEN + 1));
        @(negedge clk);
        lv_l = 1'b0;
        check_frame(1'b0, 8'b00001111, 1'b0, "hold_F0");

        // Reset pulse during data bit 3 of 8'h00 aborts the frame asynchronously.
        @(negedge clk);
        data_in = 8'h00;
        lv_l = 1'b1;
        @(negedge clk);
        lv_l = 1'b0;
        for (int i = 0; i < 4; i++) @(negedge clk);
        check("abort busy before", 32'(busy_l), 32'd1);
        check("abort q before",    32'(q_l),    32'd0);
        rst = 1'b1;
        #1;
        check("abort q async",    32'(q_l),    32'd1);
        check("abort busy async", 32'(busy_l), 32'd0);
        check("abort done async", 32'(done_l), 32'd0);
        @(negedge clk);
        check_idle("abort held");
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("abort no done[%0d]", i), 32'(done_l), 32'd0);
        end
        send(1'b0, 8'hA5, 8'b10100101, 1'b0, "after_abort");

        // Parity-sensitive words; without the parity build the slot is absent.
        send(1'b0, 8'h07, 8'b11100000, 1'b1, "par_07");
        send(1'b0, 8'h03, 8'b11000000, 1'b0, "par_03");

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL timeout: observed running expected finished");
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $fatal(1, "timeout");
    end

endmodule
